// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and sizing helper for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Iteration counter width: clog2 of the iteration count, never below one bit.
  function automatic int cnt_width(input int width, input int bpc);
    int n;
    n = width / bpc;
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/busy/done handshake and operand/result bus of the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32) ();

  logic             Start;
  logic [1:0]       Op;
  logic             Abort;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic             Busy;
  logic             Done;
  logic             Div_Zero;
  logic [WIDTH-1:0] HI_Out;
  logic [WIDTH-1:0] LO_Out;

  modport master (
    output Start, Op, Abort, Op_A, Op_B,
    input  Busy, Done, Div_Zero, HI_Out, LO_Out
  );

  modport slave (
    input  Start, Op, Abort, Op_A, Op_B,
    output Busy, Done, Div_Zero, HI_Out, LO_Out
  );

endinterface

// File: rtl/muldiv_step.sv
// Combinational iteration slice: BITS_PER_CYCLE steps of shift-add multiply
// or restoring shift-subtract divide on the {hi, lo} working pair.
module muldiv_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             mode_i,   // 1: divide, 0: multiply
  input  logic [WIDTH-1:0] hi_i,     // partial product high half / partial remainder
  input  logic [WIDTH-1:0] lo_i,     // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] b_i,      // multiplicand / divisor magnitude
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Unrolled iterations; each step consumes one lo bit.
  always_comb begin
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] l;
    logic [WIDTH:0]   t;
    h = hi_i;
    l = lo_i;
    t = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mode_i) begin
        // Shift remainder left pulling in the next dividend bit, subtract if it fits.
        t = {h, l[WIDTH-1]};
        l = {l[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, b_i}) begin
          t    = t - {1'b0, b_i};
          l[0] = 1'b1;
        end
        h = t[WIDTH-1:0];
      end else begin
        // Conditionally add multiplicand into the high half, then shift right with carry.
        t = {1'b0, h} + (l[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
        l = {t[0], l[WIDTH-1:1]};
        h = t[WIDTH:1];
      end
    end
    hi_o = h;
    lo_o = l;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine with HI/LO result registers.
// Operands are reduced to magnitudes on entry, the unsigned core iterates, and
// the FIX cycle restores signs before the result registers are written.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic     Clock,
  input  logic     Reset_N,
  muldiv_if.slave  bus
);

  localparam int             N        = WIDTH / BITS_PER_CYCLE;
  localparam int             CW       = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic             busy_q, done_q, dz_q, dz_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic             is_div_q, neg_q, rem_neg_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  logic             start_ok, op_div, op_sgn, div_zero, run_go;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Start decode and operand magnitudes.
  assign start_ok = ((state_q == IDLE) || (state_q == DONE)) && bus.Start && !bus.Abort;
  assign op_div   = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
  assign op_sgn   = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
  assign div_zero = start_ok && op_div && (bus.Op_B == '0);
  assign run_go   = start_ok && !div_zero;
  assign a_neg    = op_sgn && bus.Op_A[WIDTH-1];
  assign b_neg    = op_sgn && bus.Op_B[WIDTH-1];
  assign a_mag    = a_neg ? -bus.Op_A : bus.Op_A;
  assign b_mag    = b_neg ? -bus.Op_B : bus.Op_B;

  muldiv_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .mode_i (is_div_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .b_i    (opb_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Next-state logic; Abort overrides everything, including a same-cycle Start.
  always_comb begin
    state_d = state_q;
    dz_d    = 1'b0;
    if (bus.Abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (run_go) begin
            state_d = RUN;
          end else if (div_zero) begin
            state_d = DONE;
            dz_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RUN:     state_d = (cnt_q == CNT_LAST) ? FIX : RUN;
        FIX:     state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN) || (state_d == FIX);
      done_q  <= (state_d == DONE);
      dz_q    <= dz_d;
    end
  end

  // Working registers: load magnitudes on start, iterate while running.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (run_go) begin
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= a_mag;
      opb_q     <= b_mag;
      is_div_q  <= op_div;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end else if (state_q == RUN) begin
      cnt_q     <= cnt_q + CW'(1);
      acc_hi_q  <= step_hi;
      acc_lo_q  <= step_lo;
    end
  end

  // Sign correction: negate the full product, or quotient/remainder separately.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = neg_q     ? -acc_lo_q : acc_lo_q;
      fix_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
    end
  end

  // HI/LO change only when a completed operation leaves FIX.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if ((state_q == FIX) && (state_d == DONE)) begin
      res_hi_q <= fix_hi;
      res_lo_q <= fix_lo;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Div_Zero = dz_q;
  assign bus.HI_Out   = res_hi_q;
  assign bus.LO_Out   = res_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: two instances (1 and 2 bits per cycle) receive identical
// stimulus; expected results are queued at Start and popped on each Done.
module tb_muldiv_unit;

  localparam int N1 = 32;
  localparam int N2 = 16;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
    int          busy;
  } exp_t;

  logic Clock;
  logic Reset_N;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t q1[$];
  exp_t q2[$];
  int   bcnt1, bcnt2;
  logic [31:0] mhi, mlo;

  muldiv_if #(.WIDTH(32)) bus1 ();
  muldiv_if #(.WIDTH(32)) bus2 ();

  assign bus2.Start = bus1.Start;
  assign bus2.Op    = bus1.Op;
  assign bus2.Abort = bus1.Abort;
  assign bus2.Op_A  = bus1.Op_A;
  assign bus2.Op_B  = bus1.Op_B;

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .Clock   (Clock),
    .Reset_N (Reset_N),
    .bus     (bus1.slave)
  );

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut2 (
    .Clock   (Clock),
    .Reset_N (Reset_N),
    .bus     (bus2.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference results from native wide arithmetic.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint sa, sb, p;
    logic [63:0] u;
    e.dz = 1'b0; e.hi = mhi; e.lo = mlo; e.due = 0; e.busy = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      2'b10: begin
        if (b == 0) e.dz = 1'b1;
        else begin
          p = sa / sb; e.lo = p[31:0];
          p = sa % sb; e.hi = p[31:0];
        end
      end
      default: begin
        if (b == 0) e.dz = 1'b1;
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
  endtask

  // Drive one Start (caller is #1 after an edge); optionally queue expectations.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    exp_t e;
    int t;
    bus1.Op = op; bus1.Op_A = a; bus1.Op_B = b; bus1.Start = 1'b1;
    @(posedge Clock); #1;
    t = cyc;
    bus1.Start = 1'b0;
    if (track) begin
      model(op, a, b, e);
      if (!e.dz) begin mhi = e.hi; mlo = e.lo; end
      e.due = e.dz ? t : t + N1 + 1; e.busy = e.dz ? 0 : N1 + 1; q1.push_back(e);
      e.due = e.dz ? t : t + N2 + 1; e.busy = e.dz ? 0 : N2 + 1; q2.push_back(e);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  // Wait for the slower instance's Done; leaves the bench in the DONE cycle.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clock); #1;
      if (bus1.Done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    step_cycles(1);
    issue(op, a, b, 1'b1);
    if (op[1] && b == 0) step_cycles(2);
    else wait_done();
  endtask

  task automatic mon(input int which, input logic done, input logic dz, input logic busy,
                     input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    int bc;
    bc = (which == 1) ? bcnt1 : bcnt2;
    if (done) begin
      if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
        chk($sformatf("d%0d_unexpected_done", which), 64'd1, 64'd0);
      end else begin
        e = (which == 1) ? q1.pop_front() : q2.pop_front();
        chk($sformatf("d%0d_divzero", which), 64'(dz), 64'(e.dz));
        chk($sformatf("d%0d_hi", which), 64'(hi), 64'(e.hi));
        chk($sformatf("d%0d_lo", which), 64'(lo), 64'(e.lo));
        chk($sformatf("d%0d_latency", which), 64'(cyc), 64'(e.due));
        chk($sformatf("d%0d_busy_cycles", which), 64'(bc), 64'(e.busy));
      end
      bc = 0;
    end else if (busy) begin
      bc = bc + 1;
    end else begin
      bc = 0;
      if (dz) chk($sformatf("d%0d_dz_without_done", which), 64'd1, 64'd0);
    end
    if (which == 1) bcnt1 = bc; else bcnt2 = bc;
  endtask

  always @(negedge Clock) mon(1, bus1.Done, bus1.Div_Zero, bus1.Busy, bus1.HI_Out, bus1.LO_Out);
  always @(negedge Clock) mon(2, bus2.Done, bus2.Div_Zero, bus2.Busy, bus2.HI_Out, bus2.LO_Out);

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    cyc = 0; n_cmp = 0; n_err = 0; bcnt1 = 0; bcnt2 = 0; mhi = '0; mlo = '0;
    Reset_N = 1'b0;
    bus1.Start = 1'b0; bus1.Abort = 1'b0; bus1.Op = 2'b00; bus1.Op_A = '0; bus1.Op_B = '0;
    step_cycles(2);
    chk("rst_busy", 64'(bus1.Busy), 64'd0);
    chk("rst_done", 64'(bus1.Done), 64'd0);
    chk("rst_dz", 64'(bus1.Div_Zero), 64'd0);
    chk("rst_hi", 64'(bus1.HI_Out), 64'd0);
    chk("rst_lo", 64'(bus1.LO_Out), 64'd0);
    Reset_N = 1'b1;

    // Unsigned full-scale multiply.
    step_cycles(1);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("multu_busy_t1", 64'(bus1.Busy), 64'd1);
    wait_done();
    chk("multu_max_hi", 64'(bus1.HI_Out), 64'hFFFFFFFE);
    chk("multu_max_lo", 64'(bus1.LO_Out), 64'h00000001);

    // Signed multiply.
    run_op(2'b00, -32'sd7, 32'd3);
    chk("mult_neg_hi", 64'(bus1.HI_Out), 64'hFFFFFFFF);
    chk("mult_neg_lo", 64'(bus1.LO_Out), 64'hFFFFFFEB);

    // Signed divide, then back-to-back unsigned divide from the DONE cycle.
    run_op(2'b10, -32'sd7, 32'd2);
    chk("div_neg_lo", 64'(bus1.LO_Out), 64'hFFFFFFFD);
    chk("div_neg_hi", 64'(bus1.HI_Out), 64'hFFFFFFFF);
    issue(2'b11, 32'd7, 32'd2, 1'b1);
    wait_done();
    chk("divu_b2b_lo", 64'(bus1.LO_Out), 64'd3);
    chk("divu_b2b_hi", 64'(bus1.HI_Out), 64'd1);

    // Overflow case MIN / -1.
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min_lo", 64'(bus1.LO_Out), 64'h80000000);
    chk("div_min_hi", 64'(bus1.HI_Out), 64'd0);

    // Preload HI/LO = 0x11/0x22, then divide by zero.
    run_op(2'b11, 32'h2211, 32'h100);
    step_cycles(1);
    issue(2'b11, 32'd5, 32'd0, 1'b1);
    chk("dz_done_t1", 64'(bus1.Done), 64'd1);
    chk("dz_flag_t1", 64'(bus1.Div_Zero), 64'd1);
    step_cycles(1);
    chk("dz_done_t2", 64'(bus1.Done), 64'd0);
    chk("dz_hi_kept", 64'(bus1.HI_Out), 64'h11);
    chk("dz_lo_kept", 64'(bus1.LO_Out), 64'h22);

    // Start while busy is ignored.
    step_cycles(1);
    issue(2'b01, 32'd5, 32'd6, 1'b1);
    step_cycles(3);
    bus1.Op = 2'b00; bus1.Op_A = 32'd9; bus1.Op_B = 32'd9; bus1.Start = 1'b1;
    step_cycles(1);
    bus1.Start = 1'b0;
    wait_done();

    // Abort mid-multiply.
    step_cycles(1);
    issue(2'b00, 32'd123, 32'd456, 1'b0);
    step_cycles(9);
    bus1.Abort = 1'b1;
    step_cycles(1);
    bus1.Abort = 1'b0;
    chk("abort_busy1", 64'(bus1.Busy), 64'd0);
    chk("abort_busy2", 64'(bus2.Busy), 64'd0);
    chk("abort_hi", 64'(bus1.HI_Out), 64'(mhi));
    chk("abort_lo", 64'(bus1.LO_Out), 64'(mlo));
    step_cycles(40);

    // Abort and Start together: Start is dropped.
    bus1.Op = 2'b01; bus1.Op_A = 32'd3; bus1.Op_B = 32'd3; bus1.Start = 1'b1; bus1.Abort = 1'b1;
    step_cycles(1);
    bus1.Start = 1'b0; bus1.Abort = 1'b0;
    chk("abort_start_busy", 64'(bus1.Busy), 64'd0);
    step_cycles(40);

    // Asynchronous reset mid-divide, then a normal operation.
    issue(2'b10, 32'd1000, 32'd7, 1'b0);
    step_cycles(4);
    #2 Reset_N = 1'b0;
    #1;
    chk("arst_busy", 64'(bus1.Busy), 64'd0);
    chk("arst_done", 64'(bus1.Done), 64'd0);
    chk("arst_dz", 64'(bus1.Div_Zero), 64'd0);
    chk("arst_hi", 64'(bus1.HI_Out), 64'd0);
    chk("arst_lo", 64'(bus1.LO_Out), 64'd0);
    mhi = '0; mlo = '0;
    step_cycles(2);
    #3 Reset_N = 1'b1;
    step_cycles(1);
    run_op(2'b11, 32'd100, 32'd7);

    // Mixed random operations.
    for (int k = 0; k < 8; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (k == 3) rb = '0;
      else if (k % 2 == 1) rb = rb >> 20;
      run_op(rop, ra, rb);
    end

    step_cycles(5);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine with a start/busy/done handshake. It replaces the separate fixed-width multiplier and divider that feed the HI/LO muxes. It supports signed and unsigned multiply and divide, configurable datapath width and radix, abort, and divide-by-zero reporting to exception control. Results land directly in internal HI/LO result registers.

Parameters:
WIDTH, 32, operand and result-half width in bits; must be even, minimum 8.
BITS_PER_CYCLE, 1, bits retired per iteration; legal values 1, 2, 4; must divide WIDTH.

Ports:
Clock  input  1  rising-edge clock
Reset_N  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only when the state is IDLE or DONE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; latched with Start
Abort  input  1  cancels the operation in flight
Op_A  input  WIDTH  multiplicand/dividend; latched with Start
Op_B  input  WIDTH  multiplier/divisor; latched with Start
Busy  output  1  high in RUN or FIX
Done  output  1  one-cycle pulse when HI_Out/LO_Out have been updated, or on divide-by-zero
Div_Zero  output  1  one-cycle pulse, coincident with Done, for DIV/DIVU with Op_B==0
HI_Out  output  WIDTH  product upper half / remainder
LO_Out  output  WIDTH  product lower half / quotient

Behaviour:
- Let N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: waits for Start.
  - RUN: iterates N cycles using an iteration counter.
  - FIX: one cycle of sign correction and result write.
  - DONE: one cycle.
- Transitions:
  - IDLE/DONE + Start: go to RUN and latch operands. Exception: DIV/DIVU with Op_B==0 goes to DONE with Div_Zero.
  - DONE without Start: go to IDLE.
  - RUN: go to FIX when the counter reaches N-1.
  - FIX: go to DONE.
- Latency: Start sampled at edge t.
  - RUN occupies cycles t+1..t+N.
  - FIX occupies cycle t+N+1.
  - Done is high in cycle t+N+2, with HI_Out/LO_Out already holding the new result.
  - Divide-by-zero: Done and Div_Zero are high in cycle t+1; HI_Out/LO_Out are unchanged.
- Back-to-back: a Start in the DONE cycle is accepted. Start while Busy is ignored; no queuing.
- Signed operations: operands are converted to magnitudes on entry. Unsigned shift-add multiply and restoring divide run on the magnitudes, and FIX negates results as required.
- MULT/MULTU: {HI_Out,LO_Out} is the exact 2*WIDTH product, two's complement for MULT.
- DIV: quotient truncates toward zero. The remainder takes the sign of the dividend. MIN/-1 gives LO_Out=MIN and HI_Out=0, with no flag raised.
- DIVU: plain unsigned quotient and remainder.
- HI_Out/LO_Out are written only on the FIX->DONE edge. They hold their value otherwise, including across Abort and divide-by-zero.
- Abort: from any state, the next state is IDLE. Done and Div_Zero are not asserted and HI/LO are untouched.
- Abort and Start in the same cycle: Abort wins and Start is dropped.
- Reset_N low: immediately forces IDLE, Busy=0, Done=0, Div_Zero=0, HI_Out=0, LO_Out=0, counter and working registers 0. This applies mid-operation too, and the interrupted operation is lost.
- Op is decoded only at Start. Later changes to Op, Op_A or Op_B have no effect on the operation in flight.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State enum: IDLE, RUN, FIX, DONE.
  - A function computing the counter width, clog2(N).
- Sub-module muldiv_step: combinational, performs BITS_PER_CYCLE iterations of shift-add (multiply) or shift-subtract (divide) on the accumulator/remainder pair. It is instantiated once and selected by a mode bit.

Test Plan:
- MULTU with 0xFFFFFFFF * 0xFFFFFFFF (WIDTH=32, BPC=1), Start at t -> Done at t+34, HI=0xFFFFFFFE, LO=0x00000001, Busy high t+1..t+33.
- MULT with -7 * 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Repeat with BPC=2: same values, Done at t+18.
- DIV with -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Back-to-back Start in the DONE cycle with DIVU 7/2 -> LO=3, HI=1 after a further 34 cycles.
- DIV with 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU with 5 / 0, prior HI/LO = 0x11/0x22 -> Done and Div_Zero high at t+1 only; HI=0x11, LO=0x22 unchanged.
- Abort at t+10 mid-MULT -> Busy low from t+11, no Done, HI/LO unchanged.
- Reset_N pulled low at t+5 mid-DIV -> all outputs 0 asynchronously. After release, a Start is accepted normally.
